// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Brief    : Stall/flush sequencer for the 5-stage pipeline (load-use,
//             taken branch and multi-cycle unit hazards).
//  Revision : 1.0  initial release
// ============================================================================

`ifndef STALL_WIDTH
`define STALL_WIDTH 2
`endif
`ifndef STALL_NONE
`define STALL_NONE 2'd0
`endif
`ifndef STALL_LOAD
`define STALL_LOAD 2'd1
`endif
`ifndef STALL_BRANCH
`define STALL_BRANCH 2'd2
`endif
`ifndef STALL_MULTI
`define STALL_MULTI 2'd3
`endif
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

module pipe_ctrl #(
  parameter int LOAD_CYC    = 1,
  parameter int BRANCH_CYC  = 2,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_use_req,
  input  logic                         branch_taken,
  input  logic [`MEM_ADDR_WIDTH-1:0]   branch_target,
  input  logic                         mdu_start,
  input  logic                         mdu_done,
  output logic [`STALL_WIDTH-1:0]      stall,
  output logic                         flush_ifid,
  output logic                         flush_idex,
  output logic                         pc_redirect_en,
  output logic [`MEM_ADDR_WIDTH-1:0]   pc_redirect,
  output logic                         mdu_abort,
  output logic                         timeout_err
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_BRANCH = 2'd2;
  localparam logic [1:0] S_MULTI  = 2'd3;

  // Reload values count the remaining penalty cycles after the S_RUN cycle.
  localparam logic [7:0] c_load_reload   = 8'(LOAD_CYC - 1);
  localparam logic [7:0] c_branch_reload = 8'(BRANCH_CYC - 1);
  localparam logic [7:0] c_mdu_reload    = 8'(MDU_TIMEOUT - 1);

  logic [1:0]                   state_q, state_d;
  logic [7:0]                   cnt_q, cnt_d;
  logic                         timeout_err_q, timeout_err_d;
  logic [`MEM_ADDR_WIDTH-1:0]   pc_redirect_q, pc_redirect_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      cnt_q         <= 8'd0;
      timeout_err_q <= 1'b0;
      pc_redirect_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      pc_redirect_q <= pc_redirect_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    pc_redirect_d = pc_redirect_q;
    case (state_q)
      S_RUN: begin
        if (branch_taken) begin
          pc_redirect_d = branch_target;
          if (BRANCH_CYC > 1) begin
            state_d = S_BRANCH;
            cnt_d   = c_branch_reload;
          end
        end else if (mdu_start) begin
          state_d = S_MULTI;
          cnt_d   = c_mdu_reload;
        end else if (load_use_req) begin
          if (LOAD_CYC > 1) begin
            state_d = S_LOAD;
            cnt_d   = c_load_reload;
          end
        end
      end
      S_LOAD, S_BRANCH: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_RUN;
        end
      end
      S_MULTI: begin
        cnt_d = cnt_q - 8'd1;
        // A done arriving on the last allowed cycle still counts as success.
        if (mdu_done) begin
          state_d = S_RUN;
        end else if (cnt_q == 8'd1) begin
          state_d       = S_RUN;
          timeout_err_d = 1'b1;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_comb begin
    stall          = `STALL_NONE;
    flush_ifid     = 1'b0;
    flush_idex     = 1'b0;
    pc_redirect_en = 1'b0;
    pc_redirect    = pc_redirect_q;
    mdu_abort      = 1'b0;
    timeout_err    = timeout_err_q;
    if (rst) begin
      pc_redirect = '0;
      timeout_err = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (branch_taken) begin
            stall          = `STALL_BRANCH;
            flush_ifid     = 1'b1;
            flush_idex     = 1'b1;
            pc_redirect_en = 1'b1;
            pc_redirect    = branch_target;
          end else if (mdu_start) begin
            stall = `STALL_MULTI;
          end else if (load_use_req) begin
            stall      = `STALL_LOAD;
            flush_idex = 1'b1;
          end
        end
        S_LOAD: begin
          stall      = `STALL_LOAD;
          flush_idex = 1'b1;
        end
        S_BRANCH: begin
          stall      = `STALL_BRANCH;
          flush_ifid = 1'b1;
        end
        S_MULTI: begin
          stall     = `STALL_MULTI;
          mdu_abort = ~mdu_done && (cnt_q == 8'd1);
        end
        default: begin
          stall = `STALL_NONE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
